// File: rtl/wb_stage_mlane.sv
// N-lane writeback pipeline register with oldest-first redirect select.
// Squashes younger same-cycle lanes and counts retired writebacks.
module wb_stage_mlane #(
    parameter int LANES  = 2,
    parameter int XLEN   = 64,
    parameter int INST_W = 32,
    parameter int SID_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES-1:0]           in_valid_i,
    input  logic [LANES*5-1:0]         in_rd_i,
    input  logic [LANES*XLEN-1:0]      in_value_i,
    input  logic [LANES*INST_W-1:0]    in_inst_i,
    input  logic [LANES*(SID_W+1)-1:0] in_sid_i,
    input  logic [LANES-1:0]           in_redirect_i,
    input  logic [LANES*XLEN-1:0]      in_redirect_pc_i,
    input  logic [LANES-1:0]           stall_i,
    input  logic [LANES-1:0]           flush_i,
    input  logic                       redirect_en_i,
    output logic [LANES-1:0]           wb_valid_o,
    output logic [LANES-1:0]           wb_rf_we_o,
    output logic [LANES*5-1:0]         wb_rd_o,
    output logic [LANES*XLEN-1:0]      wb_value_o,
    output logic [LANES*INST_W-1:0]    wb_inst_o,
    output logic [LANES*(SID_W+1)-1:0] wb_sid_o,
    output logic                       wb_redirect_o,
    output logic [XLEN-1:0]            wb_redirect_pc_o,
    output logic [SID_W:0]             wb_redirect_sid_o,
    output logic [CNT_W-1:0]           retired_cnt_o
);

    localparam int SW = SID_W + 1;

    logic [LANES-1:0]  r_valid;
    logic [LANES-1:0]  r_redir;
    logic [LANES-1:0]  r_fired;
    logic [LANES-1:0]  r_counted;
    logic [4:0]        r_rd    [LANES];
    logic [XLEN-1:0]   r_value [LANES];
    logic [INST_W-1:0] r_inst  [LANES];
    logic [SW-1:0]     r_sid   [LANES];
    logic [XLEN-1:0]   r_rpc   [LANES];
    logic [CNT_W-1:0]  r_cnt;

    logic [LANES-1:0]  w_cand;
    logic [LANES-1:0]  w_ok;
    logic [LANES-1:0]  w_win;
    logic              w_any;
    logic [XLEN-1:0]   w_rpc;
    logic [SW-1:0]     w_rsid;
    logic [LANES-1:0]  w_kill;
    logic [LANES-1:0]  w_new;
    logic [CNT_W-1:0]  w_add;

    // Wrap-aware age: same epoch compares index, crossed epoch inverts it.
    function automatic logic older(input logic [SW-1:0] a,
                                   input logic [SW-1:0] b);
        if (a[SID_W] == b[SID_W])
            return a[SID_W-1:0] < b[SID_W-1:0];
        else
            return a[SID_W-1:0] > b[SID_W-1:0];
    endfunction

    // Candidates that no other candidate is older than.
    always_comb begin
        w_cand = r_valid & r_redir & ~flush_i & ~r_fired;
        w_ok   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ok[i] = w_cand[i];
            for (int j = 0; j < LANES; j++) begin
                if (j != i && w_cand[j] && older(r_sid[j], r_sid[i]))
                    w_ok[i] = 1'b0;
            end
        end
    end

    // Lowest-index eligible lane wins; falls back to any candidate.
    always_comb begin
        logic found;
        found = 1'b0;
        w_win = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!found && w_ok[i]) begin
                found    = 1'b1;
                w_win[i] = 1'b1;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (!found && w_cand[i]) begin
                found    = 1'b1;
                w_win[i] = 1'b1;
            end
        end
    end

    // Redirect target/sid mux from the one-hot winner.
    always_comb begin
        w_any  = |w_cand;
        w_rpc  = '0;
        w_rsid = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_win[i]) begin
                w_rpc  = w_rpc | r_rpc[i];
                w_rsid = w_rsid | r_sid[i];
            end
        end
    end

    assign wb_redirect_o     = redirect_en_i & w_any;
    assign wb_redirect_pc_o  = w_rpc;
    assign wb_redirect_sid_o = w_rsid;

    // Squash, output valid, rf write enable, first-cycle retire count.
    always_comb begin
        w_add = '0;
        for (int i = 0; i < LANES; i++) begin
            w_kill[i] = wb_redirect_o & r_valid[i] & older(w_rsid, r_sid[i]);
            wb_valid_o[i] = r_valid[i] & ~flush_i[i] & ~w_kill[i];
            wb_rf_we_o[i] = wb_valid_o[i] & (r_rd[i] != 5'd0);
            w_new[i] = wb_valid_o[i] & ~r_counted[i];
            w_add = w_add + CNT_W'(w_new[i]);
        end
    end

    // Flatten registered lane fields onto the output buses.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wb_rd_o[5*i +: 5]           = r_rd[i];
            wb_value_o[XLEN*i +: XLEN]  = r_value[i];
            wb_inst_o[INST_W*i +: INST_W] = r_inst[i];
            wb_sid_o[SW*i +: SW]        = r_sid[i];
        end
    end

    // Per-lane register: flush > load > hold > drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_redir   <= '0;
            r_fired   <= '0;
            r_counted <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_rd[i]    <= '0;
                r_value[i] <= '0;
                r_inst[i]  <= '0;
                r_sid[i]   <= '0;
                r_rpc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (flush_i[i]) begin
                    r_valid[i]   <= 1'b0;
                    r_redir[i]   <= 1'b0;
                    r_fired[i]   <= 1'b0;
                    r_counted[i] <= 1'b0;
                end else if (in_valid_i[i]) begin
                    r_valid[i]   <= 1'b1;
                    r_redir[i]   <= in_redirect_i[i];
                    r_fired[i]   <= 1'b0;
                    r_counted[i] <= 1'b0;
                    r_rd[i]      <= in_rd_i[5*i +: 5];
                    r_value[i]   <= in_value_i[XLEN*i +: XLEN];
                    r_inst[i]    <= in_inst_i[INST_W*i +: INST_W];
                    r_sid[i]     <= in_sid_i[SW*i +: SW];
                    r_rpc[i]     <= in_redirect_pc_i[XLEN*i +: XLEN];
                end else if (stall_i[i]) begin
                    r_fired[i]   <= r_fired[i] | (wb_redirect_o & w_win[i]);
                    r_counted[i] <= r_counted[i] | wb_valid_o[i];
                end else begin
                    r_valid[i]   <= 1'b0;
                    r_redir[i]   <= 1'b0;
                    r_fired[i]   <= 1'b0;
                    r_counted[i] <= 1'b0;
                end
            end
        end
    end

    // Retired writeback counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + w_add;
    end

    assign retired_cnt_o = r_cnt;

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Bench for wb_stage_mlane: directed scenarios plus random traffic
// checked against a transaction-level lane model.
module tb_wb_stage_mlane;

    localparam int L  = 2;
    localparam int X  = 64;
    localparam int IW = 32;
    localparam int SI = 4;
    localparam int C  = 32;
    localparam int S  = SI + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [L-1:0]    in_valid, in_redir, stall, flush;
    logic [L*5-1:0]  in_rd;
    logic [L*X-1:0]  in_value, in_rpc;
    logic [L*IW-1:0] in_inst;
    logic [L*S-1:0]  in_sid;
    logic            en;

    logic [L-1:0]    wb_valid, wb_we;
    logic [L*5-1:0]  wb_rd;
    logic [L*X-1:0]  wb_value;
    logic [L*IW-1:0] wb_inst;
    logic [L*S-1:0]  wb_sid;
    logic            wb_redir;
    logic [X-1:0]    wb_rpc;
    logic [S-1:0]    wb_rsid;
    logic [C-1:0]    cnt;

    wb_stage_mlane #(
        .LANES(L), .XLEN(X), .INST_W(IW), .SID_W(SI), .CNT_W(C)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_rd_i(in_rd), .in_value_i(in_value),
        .in_inst_i(in_inst), .in_sid_i(in_sid),
        .in_redirect_i(in_redir), .in_redirect_pc_i(in_rpc),
        .stall_i(stall), .flush_i(flush), .redirect_en_i(en),
        .wb_valid_o(wb_valid), .wb_rf_we_o(wb_we), .wb_rd_o(wb_rd),
        .wb_value_o(wb_value), .wb_inst_o(wb_inst), .wb_sid_o(wb_sid),
        .wb_redirect_o(wb_redir), .wb_redirect_pc_o(wb_rpc),
        .wb_redirect_sid_o(wb_rsid), .retired_cnt_o(cnt)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction held in a lane, plus whether its redirect/retire
    // has already been reported while it sits stalled.
    typedef struct {
        bit          v, r, fired, counted;
        bit [4:0]    rd;
        bit [X-1:0]  val;
        bit [IW-1:0] ins;
        bit [S-1:0]  sid;
        bit [X-1:0]  pc;
    } ln_t;

    ln_t m[L];
    bit [C-1:0] mcnt;

    // a is older than b when b lies 1..2^SI-1 steps ahead in sid space.
    function automatic bit is_older(bit [S-1:0] a, bit [S-1:0] b);
        bit [S-1:0] d;
        d = b - a;
        return d != 0 && d < (1 << SI);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < L; i++) m[i] = '{default: '0};
        mcnt = '0;
    endtask

    task automatic idle();
        in_valid = '0; in_redir = '0; stall = '0; flush = '0;
        in_rd = '0; in_value = '0; in_rpc = '0; in_inst = '0;
        in_sid = '0; en = 1'b1;
    endtask

    task automatic set_lane(int i, bit [4:0] rd, bit [X-1:0] v,
                            bit [S-1:0] sid, bit rdr, bit [X-1:0] pc);
        in_valid[i] = 1'b1;
        in_rd[5*i +: 5] = rd;
        in_value[X*i +: X] = v;
        in_inst[IW*i +: IW] = 32'h1000_0000 + IW'(sid);
        in_sid[S*i +: S] = sid;
        in_redir[i] = rdr;
        in_rpc[X*i +: X] = pc;
    endtask

    // Check one cycle against the model, advance the model, then
    // move to the next falling edge.
    task automatic cyc();
        bit [L-1:0] cand, kill, v, we;
        int w;
        bit rdo;
        bit [X-1:0] rpc;
        bit [S-1:0] rsid;
        int add;
        #1;
        for (int i = 0; i < L; i++)
            cand[i] = m[i].v && m[i].r && !flush[i] && !m[i].fired;
        w = -1;
        for (int i = 0; i < L; i++) begin
            bit beaten = 0;
            for (int j = 0; j < L; j++)
                if (j != i && cand[j] && is_older(m[j].sid, m[i].sid))
                    beaten = 1;
            if (cand[i] && !beaten && w < 0) w = i;
        end
        rdo  = en && (cand != 0);
        rpc  = (w >= 0) ? m[w].pc : '0;
        rsid = (w >= 0) ? m[w].sid : '0;
        add = 0;
        for (int i = 0; i < L; i++) begin
            kill[i] = rdo && m[i].v && is_older(rsid, m[i].sid);
            v[i] = m[i].v && !flush[i] && !kill[i];
            we[i] = v[i] && m[i].rd != 0;
            if (v[i] && !m[i].counted) add++;
        end
        chk("valid", 64'(wb_valid), 64'(v));
        chk("rf_we", 64'(wb_we), 64'(we));
        chk("redirect", 64'(wb_redir), 64'(rdo));
        chk("redir_pc", wb_rpc, rpc);
        chk("redir_sid", 64'(wb_rsid), 64'(rsid));
        chk("retired", 64'(cnt), 64'(mcnt));
        for (int i = 0; i < L; i++) begin
            chk($sformatf("rd%0d", i), 64'(wb_rd[5*i +: 5]), 64'(m[i].rd));
            chk($sformatf("val%0d", i), wb_value[X*i +: X], m[i].val);
            chk($sformatf("sid%0d", i), 64'(wb_sid[S*i +: S]), 64'(m[i].sid));
            chk($sformatf("inst%0d", i), 64'(wb_inst[IW*i +: IW]), 64'(m[i].ins));
        end
        for (int i = 0; i < L; i++) begin
            if (flush[i]) begin
                m[i].v = 0; m[i].r = 0; m[i].fired = 0; m[i].counted = 0;
            end else if (in_valid[i]) begin
                m[i].v = 1; m[i].r = in_redir[i];
                m[i].fired = 0; m[i].counted = 0;
                m[i].rd = in_rd[5*i +: 5];
                m[i].val = in_value[X*i +: X];
                m[i].ins = in_inst[IW*i +: IW];
                m[i].sid = in_sid[S*i +: S];
                m[i].pc = in_rpc[X*i +: X];
            end else if (stall[i]) begin
                if (rdo && w == i) m[i].fired = 1;
                if (v[i]) m[i].counted = 1;
            end else begin
                m[i].v = 0; m[i].r = 0; m[i].fired = 0; m[i].counted = 0;
            end
        end
        mcnt = mcnt + C'(add);
        @(negedge clk);
    endtask

    initial begin
        bit [C-1:0] c0;
        idle();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(wb_valid), 0);
        chk("rst_redir", 64'(wb_redir), 0);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_value", wb_value[X-1:0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single lane0 writeback
        idle(); set_lane(0, 5'd3, 64'hAA, 5'd5, 0, 0); cyc();
        idle(); #1;
        chk("t1_valid", 64'(wb_valid), 64'b01);
        chk("t1_we", 64'(wb_we), 64'b01);
        chk("t1_rd0", 64'(wb_rd[4:0]), 3);
        chk("t1_cnt0", 64'(cnt), 0);
        cyc();
        idle(); #1; chk("t1_cnt1", 64'(cnt), 1); cyc();

        // lane1 only, rd=0
        idle(); set_lane(1, 5'd0, 64'h55, 5'd2, 0, 0); cyc();
        idle(); #1;
        chk("t2_valid", 64'(wb_valid), 64'b10);
        chk("t2_we", 64'(wb_we), 64'b00);
        cyc();

        // both redirect, lane1 older across wrap
        idle();
        set_lane(0, 5'd1, 64'h11, 5'b10001, 1, 64'h100);
        set_lane(1, 5'd2, 64'h22, 5'b01110, 1, 64'h200);
        cyc();
        idle(); #1;
        chk("t3_redir", 64'(wb_redir), 1);
        chk("t3_pc", wb_rpc, 64'h200);
        chk("t3_sid", 64'(wb_rsid), 64'b01110);
        chk("t3_valid", 64'(wb_valid), 64'b10);
        cyc();

        // stalled redirect pulses once, counts once
        idle(); set_lane(0, 5'd4, 64'h44, 5'd3, 1, 64'h300); stall = 2'b01;
        cyc();
        idle(); stall = 2'b01; c0 = mcnt; #1;
        chk("t4_pulse1", 64'(wb_redir), 1); cyc();
        stall = 2'b01; #1; chk("t4_pulse2", 64'(wb_redir), 0); cyc();
        stall = 2'b01; #1; chk("t4_pulse3", 64'(wb_redir), 0); cyc();
        idle(); #1; chk("t4_cnt", 64'(cnt), 64'(c0 + 1)); cyc();

        // flush in output cycle
        idle(); set_lane(0, 5'd6, 64'h66, 5'd7, 1, 64'h400); cyc();
        idle(); flush = 2'b01; c0 = mcnt; #1;
        chk("t5_valid", 64'(wb_valid), 0);
        chk("t5_redir", 64'(wb_redir), 0);
        cyc();
        idle(); #1;
        chk("t5_valid_n", 64'(wb_valid), 0);
        chk("t5_cnt", 64'(cnt), 64'(c0));
        cyc();

        // redirect disabled: no squash, both retire
        idle(); en = 0;
        set_lane(0, 5'd7, 64'h77, 5'd4, 1, 64'h500);
        set_lane(1, 5'd8, 64'h88, 5'd6, 0, 0);
        cyc();
        idle(); en = 0; c0 = mcnt; #1;
        chk("t6_redir", 64'(wb_redir), 0);
        chk("t6_valid", 64'(wb_valid), 64'b11);
        cyc();
        idle(); #1; chk("t6_cnt", 64'(cnt), 64'(c0 + 2)); cyc();

        // reset while a redirecting lane is stalled
        idle(); set_lane(0, 5'd9, 64'h99, 5'd8, 1, 64'h600); stall = 2'b01;
        cyc();
        idle(); stall = 2'b01; cyc();
        rst_n = 1'b0; model_reset(); #1;
        chk("rs_valid", 64'(wb_valid), 0);
        chk("rs_redir", 64'(wb_redir), 0);
        chk("rs_cnt", 64'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 99) < 60)
                    set_lane(i, 5'($urandom_range(0, 3)),
                             {$urandom, $urandom}, 5'($urandom),
                             $urandom_range(0, 99) < 35,
                             {$urandom, $urandom});
                stall[i] = $urandom_range(0, 99) < 35;
                flush[i] = $urandom_range(0, 99) < 10;
            end
            en = $urandom_range(0, 99) < 80;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage_mlane.md
Name: wb_stage_mlane

Overview:
- Parametrised N-lane writeback pipeline register between execute/memory and the register file and scoreboard.
- Each lane carries its own result, instruction and scoreboard id (sid), with independent per-lane stall and flush.
- Selects the oldest redirecting lane by wrap-aware sid age compare, squashes same-cycle younger lanes, and emits a one-cycle redirect pulse gated by an enable.
- Counts retired writebacks for performance monitoring.

Parameters:
- LANES, 2, number of writeback lanes (1..8).
- XLEN, 64, result and PC width.
- INST_W, 32, instruction width.
- SID_W, 4, scoreboard index width; each sid is SID_W+1 bits, with the MSB as the wrap bit.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  LANES  per-lane result valid
- in_rd_i  in  LANES*5  destination register; lane i occupies bits [5i+4:5i]
- in_value_i  in  LANES*XLEN  result value
- in_inst_i  in  LANES*INST_W  instruction
- in_sid_i  in  LANES*(SID_W+1)  scoreboard id
- in_redirect_i  in  LANES  lane requests a redirect
- in_redirect_pc_i  in  LANES*XLEN  redirect target
- stall_i  in  LANES  per-lane hold
- flush_i  in  LANES  per-lane kill
- redirect_en_i  in  1  global redirect enable
- wb_valid_o  out  LANES  lane writeback valid
- wb_rf_we_o  out  LANES  register-file write enable
- wb_rd_o  out  LANES*5  registered rd
- wb_value_o  out  LANES*XLEN  registered value
- wb_inst_o  out  LANES*INST_W  registered instruction
- wb_sid_o  out  LANES*(SID_W+1)  registered sid
- wb_redirect_o  out  1  redirect pulse
- wb_redirect_pc_o  out  XLEN  redirect target
- wb_redirect_sid_o  out  SID_W+1  sid of the redirecting instruction
- retired_cnt_o  out  CNT_W  retired writeback count

Behaviour:
- Reset (async, rst_n=0):
  - All lane valid, redirect and data registers clear to 0; retired_cnt_o=0.
  - All outputs are therefore 0.
- Per-lane register update, independent per lane, priority order:
  - flush_i[i]: valid_r[i]<=0, redir_r[i]<=0.
  - else in_valid_i[i]: load rd, value, inst, sid, redirect, redirect_pc from lane i only; valid_r<=1.
  - else stall_i[i]: hold all fields.
  - else: valid_r<=0, redir_r<=0.
- Latency: 1 cycle from input to output.
- Age function: older(a,b) is true when:
  - a.wrap==b.wrap and a.idx<b.idx, or
  - a.wrap!=b.wrap and a.idx>b.idx.
  - Equal sids are not older.
- Redirect select (combinational on registered state):
  - Candidates: lanes with valid_r & redir_r & ~flush_i.
  - Winner: the candidate that no other candidate is older than; ties go to the lowest lane index.
  - wb_redirect_o = redirect_en_i & any candidate.
  - wb_redirect_pc_o and wb_redirect_sid_o come from the winner; both are 0 when there are no candidates.
- Redirect pulse width:
  - A held (stalled) redirecting lane asserts wb_redirect_o only on its first output cycle.
  - A per-lane fired_r bit is set when the redirect is emitted and cleared when the lane loads or clears.
  - Fired lanes are not candidates.
- Squash: kill[i] = wb_redirect_o & valid_r[i] & older(redirect_sid, sid_r[i]).
- Outputs:
  - wb_valid_o[i] = valid_r[i] & ~flush_i[i] & ~kill[i].
  - wb_rf_we_o[i] = wb_valid_o[i] & (rd_r[i]!=0).
  - The redirecting lane itself is not squashed.
- Retire counter:
  - Each cycle adds popcount(wb_valid_o).
  - Wraps modulo 2^CNT_W.
  - A stalled lane is counted once: only on its first valid output cycle, using the same first-cycle tracking as fired_r.
- Simultaneous events:
  - flush with in_valid: flush wins.
  - stall with in_valid: load wins.
  - flush of the winning lane: that lane is removed from candidates and arbitration proceeds among the rest in the same cycle.
- redirect_en_i=0: no redirect output and no squash; lanes otherwise behave normally.
- Reset mid-stall: all state cleared; no redirect or count is emitted after rst_n deasserts.

Test Plan:
- Lane0 valid rd=3 value=0xAA sid=5, lane1 idle -> next cycle wb_valid_o=01, wb_rf_we_o=01, wb_rd_o lane0=3; retired_cnt_o goes 0 to 1.
- Lane1 only valid (rd=0, sid=2) -> wb_valid_o=10, wb_rf_we_o=00, and lane0 stays invalid (no cross-lane load).
- Both lanes redirect, sid lane0=0b1_0001 and lane1=0b0_1110 (lane1 older across wrap), redirect_en=1 -> wb_redirect_o=1, pc=lane1 pc, sid=0b0_1110, lane0 squashed, so wb_valid_o=10.
- Lane0 redirect sid=3 with stall held 3 cycles -> wb_redirect_o high 1 cycle only; retired_cnt_o increments by 1 total.
- Lane0 loaded, then flush_i[0]=1 in its output cycle -> wb_valid_o[0]=0 the same cycle and valid_r=0 the next; no redirect and no count.
- redirect_en_i=0 with a lane0 redirect -> wb_redirect_o=0, both lanes valid and counted (+2).
